// File: rtl/filterbank_pkg.sv
// -----------------------------------------------------------------------------
// filterbank_pkg
// Shared constants and the state type for the 16-channel serial filterbank
// sequencer. The filter is odd-length and symmetric, so each output needs
// (NUM_TAPS+1)/2 multiply-accumulate phases. Each phase handles one mirrored
// tap pair. The last phase handles the lone center tap.
// -----------------------------------------------------------------------------
package filterbank_pkg;

    localparam int NUM_TAPS   = 119;
    localparam int NUM_PHASES = (NUM_TAPS + 1) / 2;   // 60
    localparam int PHASE_W    = 6;
    localparam int TAP_W      = 7;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/filterbank_scheduler_if.sv
// -----------------------------------------------------------------------------
// filterbank_scheduler_if
// Control bundle between the sample source, the scheduler and the shared
// delay line / filter cores.
//   slave  : scheduler side (takes enable/strobe/clear, drives the sequencing)
//   master : source/core side (the mirror image)
// -----------------------------------------------------------------------------
interface filterbank_scheduler_if;

    logic                                 clk_enable;
    logic                                 sample_strobe;
    logic                                 overrun_clear;
    logic                                 shift_en;
    logic [filterbank_pkg::PHASE_W-1:0]   phase;
    logic [filterbank_pkg::TAP_W-1:0]     tap_a;
    logic [filterbank_pkg::TAP_W-1:0]     tap_b;
    logic                                 center_tap;
    logic                                 acc_clear;
    logic                                 acc_en;
    logic                                 out_valid;
    logic                                 busy;
    logic                                 overrun;
    logic [filterbank_pkg::CNT_W-1:0]     sample_count;

    modport slave (
        input  clk_enable, sample_strobe, overrun_clear,
        output shift_en, phase, tap_a, tap_b, center_tap, acc_clear, acc_en,
               out_valid, busy, overrun, sample_count
    );

    modport master (
        output clk_enable, sample_strobe, overrun_clear,
        input  shift_en, phase, tap_a, tap_b, center_tap, acc_clear, acc_en,
               out_valid, busy, overrun, sample_count
    );

endinterface

// File: rtl/fb_tap_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_tap_addr_gen
// Combinational map from a MAC phase to the symmetric tap pair it serves.
//   phase_i      : MAC phase 0..NUM_PHASES-1
//   tap_a_o      : first tap of the pair (= phase)
//   tap_b_o      : mirrored tap (= NUM_TAPS-1-phase)
//   center_tap_o : phase is the center tap (tap_a == tap_b), add it only once
// -----------------------------------------------------------------------------
module fb_tap_addr_gen
    import filterbank_pkg::*;
(
    input  logic [PHASE_W-1:0] phase_i,
    output logic [TAP_W-1:0]   tap_a_o,
    output logic [TAP_W-1:0]   tap_b_o,
    output logic               center_tap_o
);

    assign tap_a_o      = TAP_W'(phase_i);
    assign tap_b_o      = TAP_W'(NUM_TAPS - 1) - TAP_W'(phase_i);
    assign center_tap_o = (phase_i == PHASE_W'(NUM_PHASES - 1));

endmodule

// File: rtl/filterbank_scheduler.sv
// -----------------------------------------------------------------------------
// filterbank_scheduler
// Clock-enable sequencer for the 16-channel serial filterbank. Each accepted
// sample strobe causes one delay-line shift, then a sweep of the 60 symmetric
// MAC phases, then a one-cycle out_valid.
//   clock, reset : system clock, asynchronous active-low reset
//   bus (slave)  : clk_enable / sample_strobe / overrun_clear in;
//                  shift_en, phase, tap_a/tap_b/center_tap, acc_clear,
//                  acc_en, out_valid, busy, overrun, sample_count out
// -----------------------------------------------------------------------------
module filterbank_scheduler
    import filterbank_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    filterbank_scheduler_if.slave bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DONE  = DONE;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    logic [1:0]         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovr_q,   ovr_d;

    logic en;
    logic strobe;
    assign en     = bus.clk_enable;
    assign strobe = bus.sample_strobe;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (strobe) begin
                        state_d = S_SHIFT;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    state_d = S_RUN;
                    phase_d = '0;
                end
                S_RUN: begin
                    if (phase_q == LAST_PHASE) begin
                        state_d = S_DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: begin
                    // DONE accepts a back-to-back strobe straight into SHIFT.
                    if (strobe) begin
                        state_d = S_SHIFT;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
            // Set is evaluated after clear so a simultaneous new overrun wins.
            if (bus.overrun_clear) ovr_d = 1'b0;
            if (strobe && (state_q == S_SHIFT || state_q == S_RUN)) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    fb_tap_addr_gen u_addr (
        .phase_i      (phase_q),
        .tap_a_o      (bus.tap_a),
        .tap_b_o      (bus.tap_b),
        .center_tap_o (bus.center_tap)
    );

    // Strobe-like controls are masked by the enable so a stalled cycle never
    // shifts the delay line or touches the accumulators.
    assign bus.shift_en     = en && (state_q == S_SHIFT);
    assign bus.acc_en       = en && (state_q == S_RUN);
    assign bus.acc_clear    = en && (state_q == S_RUN) && (phase_q == '0);
    assign bus.out_valid    = en && (state_q == S_DONE);
    assign bus.busy         = (state_q == S_SHIFT) || (state_q == S_RUN);
    assign bus.phase        = phase_q;
    assign bus.overrun      = ovr_q;
    assign bus.sample_count = cnt_q;

endmodule

// File: doc/filterbank_scheduler.md
Name: filterbank_scheduler

Overview:
- Sequencer for the 16-channel serial filterbank. It replaces the gated phase clock with clean clock-enable control.
- For every accepted input sample it:
  - issues one delay-line shift;
  - sweeps the 60 symmetric coefficient phases, driving the tap-pair addresses, accumulator controls and center-tap flag shared by all 16 filters;
  - flags when the filter outputs are valid.
- Sits between the sample source and the shared delay line / filter cores.

Parameters:
- NUM_TAPS, 119, filter length (odd, symmetric).
- NUM_PHASES, 60, (NUM_TAPS+1)/2 MAC phases per sample.
- PHASE_W, 6, width of the phase counter.
- TAP_W, 7, width of the tap index.
- CNT_W, 16, width of the sample counter.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- clk_enable, in, 1, global enable; when 0 all state holds and pulse outputs are forced 0.
- sample_strobe, in, 1, one-cycle pulse meaning a new filter_in sample is present.
- overrun_clear, in, 1, clears the sticky overrun flag.
- shift_en, out, 1, delay-line advance enable (one cycle per accepted sample).
- phase, out, PHASE_W, current MAC phase 0..59.
- tap_a, out, TAP_W, delay-line index of the first tap of the pair (= phase).
- tap_b, out, TAP_W, delay-line index of the mirrored tap (= NUM_TAPS-1-phase).
- center_tap, out, 1, high when tap_a==tap_b (phase 59); cores add the tap once, not twice.
- acc_clear, out, 1, accumulators load the product instead of adding.
- acc_en, out, 1, accumulators update this cycle.
- out_valid, out, 1, one-cycle pulse; filter_out of all 16 cores is valid.
- busy, out, 1, high in SHIFT and RUN.
- overrun, out, 1, sticky: a strobe was dropped.
- sample_count, out, CNT_W, number of accepted samples, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; phase=0; tap_a=0; tap_b=118.
  - shift_en, center_tap, acc_clear, acc_en, out_valid, busy and overrun all 0; sample_count=0.
- All state updates are gated by clk_enable. With clk_enable=0 the FSM, counters and overrun hold, and shift_en/acc_en/acc_clear/out_valid are 0. A strobe arriving while clk_enable=0 is ignored (not counted, not an overrun).
- FSM states: IDLE, SHIFT, RUN, DONE.
  - IDLE: strobe -> SHIFT; sample_count++.
  - SHIFT: shift_en=1 for exactly this cycle; next RUN with phase=0.
  - RUN:
    - acc_en=1; acc_clear=1 only at phase 0; center_tap=1 only at phase NUM_PHASES-1.
    - Phase increments each cycle.
    - At phase NUM_PHASES-1 the next state is DONE and phase returns to 0.
  - DONE: out_valid=1 for this one cycle. Strobe -> SHIFT (back-to-back accepted, sample_count++); otherwise -> IDLE.
- Latency: strobe sampled at edge E0 gives shift_en in cycle 1, RUN phases in cycles 2..61, out_valid in cycle 62. Minimum strobe spacing is 62 cycles.
- Outputs are registered. tap_a, tap_b and center_tap are derived from the phase register and are valid whenever acc_en=1. In IDLE, SHIFT and DONE, phase=0, tap_a=0 and tap_b=118.
- Overrun:
  - A strobe in SHIFT or RUN is dropped and sets overrun; the sweep is not disturbed.
  - overrun_clear clears the flag; if a new overrun occurs in the same cycle, set wins.
- sample_count wraps from 0xFFFF to 0 without a flag.
- Reset mid-sweep aborts immediately to IDLE with all outputs at their reset values; no out_valid is produced for the aborted sample.

Decomposition:
- Package filterbank_pkg: NUM_TAPS, NUM_PHASES, PHASE_W, TAP_W, and the enumerated state type sched_state_t {IDLE, SHIFT, RUN, DONE}.
- One natural sub-module, fb_tap_addr_gen: combinational phase -> tap_a/tap_b/center_tap mapping, reusable by the filter cores' coefficient ROM addressing.
- The FSM and counters stay in filterbank_scheduler.

Test Plan:
- Reset released, single strobe at cycle 0 -> shift_en high only in cycle 1; acc_clear in cycle 2 with tap_a=0, tap_b=118; center_tap in cycle 61 with tap_a=tap_b=59; out_valid in cycle 62; busy 0 from cycle 62; sample_count=1.
- Strobes every 62 cycles for 10 samples -> every strobe arrives in DONE and is accepted, shift_en follows 1 cycle after each, overrun stays 0, sample_count=10, exactly 10 out_valid pulses.
- Strobe at cycle 0 and again at cycle 30 -> second strobe dropped, overrun=1 from cycle 31, sample_count=1, one out_valid at cycle 62; overrun_clear together with a new overrun strobe -> overrun stays 1.
- clk_enable dropped for 5 cycles at phase 20 -> phase holds at 20, acc_en=0 during the gap, sweep resumes, out_valid delayed to cycle 67.
- Reset asserted at phase 40, released, then strobe -> immediate IDLE with all outputs at reset values, no out_valid for the aborted sample, next sweep completes normally with sample_count=1.
- sample_count preloaded (forced) to 0xFFFF, one strobe -> sample_count=0x0000, normal sweep.
